// File: rtl/fetch_prefetch_unit_pkg.sv
// rtl/fetch_prefetch_unit_pkg.sv - shared definitions for the fetch prefetch unit
// Contents: XLEN, default reset PC, canonical NOP encoding, FIFO entry layout and
// a word-alignment helper used on redirect targets.
package fetch_prefetch_unit_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;

  // One buffered fetch: the instruction word and the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_sync_fifo.sv
// rtl/fetch_prefetch_unit_sync_fifo.sv - in-order synchronous FIFO with flush
// Ports:
//   clk_i    in   clock
//   reset_i  in   synchronous active-high reset
//   push_i   in   write data_i at tail (ignored when full unless popping)
//   data_i   in   WIDTH entry to write
//   pop_i    in   remove head (ignored when empty)
//   flush_i  in   discard all entries; overrides push and pop
//   data_o   out  head entry (undefined content when empty)
//   full_o   out  DEPTH entries held
//   empty_o  out  no entries held
//   count_o  out  number of entries held
module fetch_prefetch_unit_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - instruction fetch front end with prefetch buffer
// Ports:
//   clk_i             in   core clock
//   reset_i           in   synchronous active-high reset
//   mem_req_valid_o   out  fetch request valid
//   mem_req_ready_i   in   memory accepts request
//   mem_req_addr_o    out  word-aligned fetch address
//   mem_rsp_valid_i   in   in-order response valid, no backpressure
//   mem_rsp_data_i    in   instruction word
//   redirect_valid_i  in   flush and restart fetch
//   redirect_pc_i     in   new fetch address, bits [1:0] ignored
//   instr_valid_o     out  buffer head valid
//   instr_ready_i     in   decode consumes head
//   instr_o           out  head instruction word (0 when invalid)
//   instr_pc_o        out  head instruction address (0 when invalid)
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk_i,
  input  logic            reset_i,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic [XLEN-1:0] mem_req_addr_o,
  input  logic            mem_rsp_valid_i,
  input  logic [XLEN-1:0] mem_rsp_data_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    fifo_head, fifo_wdata;

  logic [CW-1:0]   live;
  logic [CW:0]     credit_sum;
  logic            req_fire, rsp_take, push, pop, head_valid;

  // Requests still owed to the buffer; squashed ones are excluded so a redirect
  // does not starve fetch while stale responses drain.
  assign live       = inflight_q - discard_q;
  assign credit_sum = {1'b0, fifo_count} + {1'b0, live};

  assign mem_req_valid_o = !reset_i && !redirect_valid_i &&
                           (credit_sum < (CW+1)'(DEPTH)) &&
                           (inflight_q < CW'(DEPTH));
  assign mem_req_addr_o  = fetch_pc_q;
  assign req_fire        = mem_req_valid_o && mem_req_ready_i;

  // A response with nothing outstanding is unsolicited and leaves all state alone.
  assign rsp_take   = mem_rsp_valid_i && (inflight_q != '0);
  assign head_valid = !fifo_empty && !reset_i;
  assign pop        = head_valid && instr_ready_i && !redirect_valid_i;
  assign push       = rsp_take && !redirect_valid_i && (discard_q == '0) &&
                      (!fifo_full || pop);

  assign fifo_wdata = '{pc: rsp_pc_q, instr: mem_rsp_data_i};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    discard_d  = discard_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_take);
    if (redirect_valid_i) begin
      // Everything still outstanding after this cycle belongs to the old path.
      discard_d  = inflight_q - CW'(rsp_take);
      fetch_pc_d = word_align(redirect_pc_i);
      rsp_pc_d   = word_align(redirect_pc_i);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_take && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (push) rsp_pc_d = rsp_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  fetch_prefetch_unit_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .data_i  (fifo_wdata),
    .pop_i   (pop),
    .flush_i (redirect_valid_i),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign instr_valid_o = head_valid;
  assign instr_o       = head_valid ? fifo_head.instr : '0;
  assign instr_pc_o    = head_valid ? fifo_head.pc    : '0;

endmodule
